// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared types and constants for the 2:1 mux round-robin arbiter.
//   arb_state_e  : FSM state encoding (IDLE / GNT_A / GNT_B)
//   SEL_A/SEL_B  : mux select values; also used as the priority-pointer value
//   PKT_CNT_W    : width of the per-side packet statistics counters
//   TO_CNT_W     : width of the timeout statistics counter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int PKT_CNT_W = 16;
  localparam int TO_CNT_W  = 8;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: handshake bundle between the two requesters, the
// arbiter and the consumer downstream of the mux.
//   req_a/req_b     : requester has a beat on mux input a/b
//   last_a/last_b   : beat is end of packet (sampled on a transfer only)
//   out_ready       : downstream accepts the mux output
//   gnt_a/gnt_b     : ownership of the mux
//   sel             : mux select, 0 = a, 1 = b
//   out_valid       : mux output carries a valid beat
//   timeout         : one-cycle pulse after a forced release
//   pkt_cnt_a/b, to_cnt : statistics, only with MUX_RR_ARBITER_STATS_EN
// modport master: requester/consumer side; modport slave: arbiter side.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic req_a;
  logic req_b;
  logic last_a;
  logic last_b;
  logic out_ready;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic out_valid;
  logic timeout;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_a;
  logic [PKT_CNT_W-1:0] pkt_cnt_b;
  logic [TO_CNT_W-1:0]  to_cnt;
`endif

  modport master (
    output req_a, req_b, last_a, last_b, out_ready,
`ifdef MUX_RR_ARBITER_STATS_EN
    input  pkt_cnt_a, pkt_cnt_b, to_cnt,
`endif
    input  gnt_a, gnt_b, sel, out_valid, timeout
  );

  modport slave (
    input  req_a, req_b, last_a, last_b, out_ready,
`ifdef MUX_RR_ARBITER_STATS_EN
    output pkt_cnt_a, pkt_cnt_b, to_cnt,
`endif
    output gnt_a, gnt_b, sel, out_valid, timeout
  );

endinterface

// File: rtl/mux_rr_arbiter_sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear and saturation at
// all-ones. Clear has priority over increment.
//   clk, rst_n : clock, async active-low reset (count resets to 0)
//   clr_i      : synchronous clear
//   inc_i      : increment by one unless already saturated
//   cnt_o      : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && ~&cnt_q)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin, packet-locked arbiter driving the select of a
// 2:1 mux, with a valid/ready handshake toward the mux consumer and a beat
// watchdog that forces release after HOLD_MAX beats without last.
//   clk, rst_n : clock, async active-low reset
//   bus        : mux_rr_arbiter_if.slave (requests, last, ready in;
//                grants, sel, out_valid, timeout out)
// Parameters: HOLD_MAX (1..255) beats per grant, CNT_W beat counter width
// with 2**CNT_W > HOLD_MAX.
// Optional: define MUX_RR_ARBITER_STATS_EN to add saturating per-side packet
// counters and a timeout counter on the interface.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_q;
  logic             ptr_q;       // side favoured on contention (SEL_A/SEL_B)
  logic             timeout_q;
  logic [CNT_W-1:0] beat_q;

  logic own_req, own_last;
  logic xfer, rel, rel_force;
  logic beat_clr, beat_inc;

  // Request/last of whichever side currently owns the mux.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    case (state_q)
      GNT_A: begin own_req = bus.req_a; own_last = bus.last_a; end
      GNT_B: begin own_req = bus.req_b; own_last = bus.last_b; end
      default: ;
    endcase
  end

  // out_valid is exactly own_req, so a transfer is own_req & out_ready.
  assign xfer      = own_req & bus.out_ready;
  // last on the limit beat is a normal release, not a forced one.
  assign rel_force = xfer & ~own_last & (beat_q == BEAT_LIM);
  assign rel       = (xfer & own_last) | rel_force;

  // Holding the counter clear while IDLE covers the "cleared on entry" case.
  assign beat_clr = rel | (state_q == IDLE);
  assign beat_inc = xfer & ~rel;

  sat_counter #(.W(CNT_W)) u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (beat_clr),
    .inc_i (beat_inc),
    .cnt_o (beat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= SEL_A;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= rel_force;
      case (state_q)
        IDLE: begin
          if (bus.req_a && (!bus.req_b || ptr_q == SEL_A)) state_q <= GNT_A;
          else if (bus.req_b)                              state_q <= GNT_B;
        end
        GNT_A: begin
          if (rel) begin
            ptr_q <= SEL_B;
            // Hand straight over to the other side to avoid an IDLE bubble.
            if (bus.req_b)      state_q <= GNT_B;
            else if (bus.req_a) state_q <= GNT_A;
            else                state_q <= IDLE;
          end
        end
        GNT_B: begin
          if (rel) begin
            ptr_q <= SEL_A;
            if (bus.req_a)      state_q <= GNT_A;
            else if (bus.req_b) state_q <= GNT_B;
            else                state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_a     = (state_q == GNT_A);
  assign bus.gnt_b     = (state_q == GNT_B);
  assign bus.sel       = (state_q == GNT_B) ? SEL_B : SEL_A;
  assign bus.out_valid = own_req;
  assign bus.timeout   = timeout_q;

`ifdef MUX_RR_ARBITER_STATS_EN
  sat_counter #(.W(PKT_CNT_W)) u_pkt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (rel & (state_q == GNT_A)),
    .cnt_o (bus.pkt_cnt_a)
  );

  sat_counter #(.W(PKT_CNT_W)) u_pkt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (rel & (state_q == GNT_B)),
    .cnt_o (bus.pkt_cnt_b)
  );

  // Counts timeout pulses, so it lags the forced release by one cycle.
  sat_counter #(.W(TO_CNT_W)) u_to (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (timeout_q),
    .cnt_o (bus.to_cnt)
  );
`endif

endmodule
